hazard_decode_stage: RTL and testbench

HAZARD_DECODE_STAGE -- requirements
Module: hazard_decode_stage

---
 rtl/hazard_decode_stage.sv | 183 ++++++++++++++++++
 tb/tb_hazard_decode_stage.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_decode_stage.sv
// hazard_decode_stage
// Decode-to-execute pipeline stage with a 2-entry (head + skid) buffer and a
// load-use interlock. The head register drives the outputs; the skid register
// absorbs one extra instruction while execute is back-pressuring.
// Optional feature: define DECODE_WB_BYPASS_EN to forward the writeback port
// into captured and held operands. Without it, operands come only from the
// register file read data and never change while held.
module hazard_decode_stage #(
    parameter int XLEN  = 32,
    parameter int PC_W  = 30,
    parameter int CTR_W = 13
) (
    input  logic             clk,
    input  logic             async_rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst_in,
    input  logic [PC_W-1:0]  pc_in,
    input  logic [CTR_W-1:0] ctr_in,
    input  logic [XLEN-1:0]  rs1_data_in,
    input  logic [XLEN-1:0]  rs2_data_in,
    input  logic             wb_we,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             ex_load_pending,
    input  logic [4:0]       ex_load_rd,
    input  logic             invalidate,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      inst_out,
    output logic [PC_W-1:0]  pc_out,
    output logic [CTR_W-1:0] ctr_out,
    output logic [XLEN-1:0]  rs1_out,
    output logic [XLEN-1:0]  rs2_out,
    output logic             hazard_stall
);

    // Head (output) entry
    logic                      r_head_valid;
    logic [31:0]               r_head_inst;
    logic [PC_W-1:0]           r_head_pc;
    logic [CTR_W-1:0]          r_head_ctr;
    logic [1:0][XLEN-1:0]      r_head_op;

    // Skid entry
    logic                      r_skid_valid;
    logic [31:0]               r_skid_inst;
    logic [PC_W-1:0]           r_skid_pc;
    logic [CTR_W-1:0]          r_skid_ctr;
    logic [1:0][XLEN-1:0]      r_skid_op;

    logic                      w_hazard;
    logic                      w_accept;
    logic                      w_pop;
    logic                      w_load_head;
    logic                      w_load_skid;
    logic                      w_move_skid;

    // Per-operand (index 0 = rs1, 1 = rs2) register fields and operand values
    logic [1:0][4:0]           w_in_rs;
    logic [1:0][4:0]           w_head_rs;
    logic [1:0][4:0]           w_skid_rs;
    logic [1:0][XLEN-1:0]      w_rf_op;
    logic [1:0][XLEN-1:0]      w_cap_op;
    logic [1:0][XLEN-1:0]      w_head_op_upd;
    logic [1:0][XLEN-1:0]      w_skid_op_upd;

    // Load-use interlock: compare against both source fields even if the
    // instruction format does not use them; a spurious stall is harmless.
    assign w_hazard = ex_load_pending && (ex_load_rd != 5'd0) &&
                      ((ex_load_rd == inst_in[19:15]) || (ex_load_rd == inst_in[24:20]));

    assign hazard_stall = in_valid && w_hazard;
    assign in_ready     = !r_skid_valid && !w_hazard;
    assign w_accept     = in_valid && in_ready && !invalidate;
    assign w_pop        = r_head_valid && out_ready;
    // Head gets the new entry if it is free or draining this cycle; a pop with
    // a full skid never coincides with an accept because in_ready is low then.
    assign w_load_head  = w_accept && (!r_head_valid || w_pop);
    assign w_load_skid  = w_accept && r_head_valid && !w_pop;
    assign w_move_skid  = w_pop && r_skid_valid;

    assign w_rf_op[0] = rs1_data_in;
    assign w_rf_op[1] = rs2_data_in;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_op
            assign w_in_rs[gi]   = inst_in[15 + 5*gi +: 5];
            assign w_head_rs[gi] = r_head_inst[15 + 5*gi +: 5];
            assign w_skid_rs[gi] = r_skid_inst[15 + 5*gi +: 5];
`ifdef DECODE_WB_BYPASS_EN
            // A write to x0 never qualifies; it would otherwise clobber
            // operands of instructions that read x0.
            logic w_wb_q;
            assign w_wb_q = wb_we && (wb_rd != 5'd0);
            assign w_cap_op[gi]      = (w_wb_q && (wb_rd == w_in_rs[gi]))   ? wb_data : w_rf_op[gi];
            assign w_head_op_upd[gi] = (w_wb_q && (wb_rd == w_head_rs[gi])) ? wb_data : r_head_op[gi];
            assign w_skid_op_upd[gi] = (w_wb_q && (wb_rd == w_skid_rs[gi])) ? wb_data : r_skid_op[gi];
`else
            assign w_cap_op[gi]      = w_rf_op[gi];
            assign w_head_op_upd[gi] = r_head_op[gi];
            assign w_skid_op_upd[gi] = r_skid_op[gi];
`endif
        end
    endgenerate

`ifndef DECODE_WB_BYPASS_EN
    // Writeback port and field decodes are only consumed by the bypass path.
    logic w_unused_wb;
    assign w_unused_wb = ^{wb_we, wb_rd, wb_data, w_in_rs, w_head_rs, w_skid_rs};
`endif

    // Valid bits: flush wins over everything, otherwise track accept/pop.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_head_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (invalidate) begin
            r_head_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            if (w_load_head) begin
                r_head_valid <= 1'b1;
            end else if (w_pop) begin
                r_head_valid <= r_skid_valid;
            end
            if (w_load_skid) begin
                r_skid_valid <= 1'b1;
            end else if (w_pop) begin
                r_skid_valid <= 1'b0;
            end
        end
    end

    // Head payload: capture new input, promote the skid, or hold (with refresh).
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_head_inst <= '0;
            r_head_pc   <= '0;
            r_head_ctr  <= '0;
            r_head_op   <= '0;
        end else if (w_load_head) begin
            r_head_inst <= inst_in;
            r_head_pc   <= pc_in;
            r_head_ctr  <= ctr_in;
            r_head_op   <= w_cap_op;
        end else if (w_move_skid) begin
            r_head_inst <= r_skid_inst;
            r_head_pc   <= r_skid_pc;
            r_head_ctr  <= r_skid_ctr;
            r_head_op   <= w_skid_op_upd;
        end else begin
            r_head_op   <= w_head_op_upd;
        end
    end

    // Skid payload: capture when the head is occupied and stalled, else hold.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            r_skid_inst <= '0;
            r_skid_pc   <= '0;
            r_skid_ctr  <= '0;
            r_skid_op   <= '0;
        end else if (w_load_skid) begin
            r_skid_inst <= inst_in;
            r_skid_pc   <= pc_in;
            r_skid_ctr  <= ctr_in;
            r_skid_op   <= w_cap_op;
        end else begin
            r_skid_op   <= w_skid_op_upd;
        end
    end

    assign out_valid = r_head_valid;
    assign inst_out  = r_head_inst;
    assign pc_out    = r_head_pc;
    // An empty head must look like a NOP to execute.
    assign ctr_out   = r_head_valid ? r_head_ctr : '0;
    assign rs1_out   = r_head_op[0];
    assign rs2_out   = r_head_op[1];

endmodule

// File: tb/tb_hazard_decode_stage.sv
// Directed, table-driven bench for hazard_decode_stage plus hand-written
// sequences for operand forwarding/holding and asynchronous reset.
module tb_hazard_decode_stage;

    localparam int XLEN  = 32;
    localparam int PC_W  = 30;
    localparam int CTR_W = 13;

    logic             clk;
    logic             async_rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      inst_in;
    logic [PC_W-1:0]  pc_in;
    logic [CTR_W-1:0] ctr_in;
    logic [XLEN-1:0]  rs1_data_in;
    logic [XLEN-1:0]  rs2_data_in;
    logic             wb_we;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             ex_load_pending;
    logic [4:0]       ex_load_rd;
    logic             invalidate;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      inst_out;
    logic [PC_W-1:0]  pc_out;
    logic [CTR_W-1:0] ctr_out;
    logic [XLEN-1:0]  rs1_out;
    logic [XLEN-1:0]  rs2_out;
    logic             hazard_stall;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_decode_stage #(.XLEN(XLEN), .PC_W(PC_W), .CTR_W(CTR_W)) dut (
        .clk             (clk),
        .async_rst_n     (async_rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .inst_in         (inst_in),
        .pc_in           (pc_in),
        .ctr_in          (ctr_in),
        .rs1_data_in     (rs1_data_in),
        .rs2_data_in     (rs2_data_in),
        .wb_we           (wb_we),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data),
        .ex_load_pending (ex_load_pending),
        .ex_load_rd      (ex_load_rd),
        .invalidate      (invalidate),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .inst_out        (inst_out),
        .pc_out          (pc_out),
        .ctr_out         (ctr_out),
        .rs1_out         (rs1_out),
        .rs2_out         (rs2_out),
        .hazard_stall    (hazard_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             iv;
        logic [31:0]      inst;
        logic [PC_W-1:0]  pc;
        logic [CTR_W-1:0] ctr;
        logic [XLEN-1:0]  r1;
        logic [XLEN-1:0]  r2;
        logic             ordy;
        logic             lp;
        logic [4:0]       lrd;
        logic             inv;
        logic             e_ir;
        logic             e_st;
        logic             e_ov;
        logic             chk;
        logic [PC_W-1:0]  e_pc;
        logic [CTR_W-1:0] e_ctr;
        logic [XLEN-1:0]  e_r1;
    } vec_t;

    // Operand data is derived from the PC so payload ordering is checked too.
    function automatic vec_t mk(input logic iv, input logic [31:0] inst,
                                input logic [PC_W-1:0] pc, input logic [CTR_W-1:0] ctr,
                                input logic ordy, input logic lp, input logic [4:0] lrd,
                                input logic inv, input logic e_ir, input logic e_st,
                                input logic e_ov, input logic [PC_W-1:0] e_pc,
                                input logic [CTR_W-1:0] e_ctr);
        vec_t v;
        v.iv = iv; v.inst = inst; v.pc = pc; v.ctr = ctr;
        v.r1 = 32'h0000_1000 | 32'(pc);
        v.r2 = 32'h0000_2000 | 32'(pc);
        v.ordy = ordy; v.lp = lp; v.lrd = lrd; v.inv = inv;
        v.e_ir = e_ir; v.e_st = e_st; v.e_ov = e_ov; v.chk = e_ov;
        v.e_pc = e_pc; v.e_ctr = e_ctr;
        v.e_r1 = 32'h0000_1000 | 32'(e_pc);
        return v;
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; inst_in = 32'h0; pc_in = '0; ctr_in = '0;
        rs1_data_in = '0; rs2_data_in = '0;
        wb_we = 1'b0; wb_rd = 5'd0; wb_data = '0;
        ex_load_pending = 1'b0; ex_load_rd = 5'd0;
        invalidate = 1'b0; out_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        @(negedge clk);
        in_valid = v.iv; inst_in = v.inst; pc_in = v.pc; ctr_in = v.ctr;
        rs1_data_in = v.r1; rs2_data_in = v.r2; out_ready = v.ordy;
        ex_load_pending = v.lp; ex_load_rd = v.lrd; invalidate = v.inv;
        #1;
        cmp($sformatf("v%0d in_ready", idx), 64'(in_ready), 64'(v.e_ir));
        cmp($sformatf("v%0d hazard_stall", idx), 64'(hazard_stall), 64'(v.e_st));
        @(posedge clk);
        #1;
        cmp($sformatf("v%0d out_valid", idx), 64'(out_valid), 64'(v.e_ov));
        cmp($sformatf("v%0d ctr_out", idx), 64'(ctr_out), 64'(v.e_ctr));
        if (v.chk) begin
            cmp($sformatf("v%0d pc_out", idx), 64'(pc_out), 64'(v.e_pc));
            cmp($sformatf("v%0d rs1_out", idx), 64'(rs1_out), 64'(v.e_r1));
        end
        $display("[TB] vec %0d: in_valid=%0d pc_in=0x%0h -> out_valid=%0d pc_out=0x%0h ctr_out=0x%0h",
                 idx, v.iv, v.pc, out_valid, pc_out, ctr_out);
    endtask

    localparam logic [31:0] I_ADD  = 32'h0020_8033; // rs1=1, rs2=2
    localparam logic [31:0] I_X0   = 32'h0000_0033; // rs1=0, rs2=0
    localparam logic [31:0] I_RS15 = 32'h0002_8000; // rs1=5, rs2=0

    vec_t vecs[20];

    initial begin
        logic [XLEN-1:0] exp_r1;
        logic [XLEN-1:0] exp_r2;

        // iv inst pc ctr ordy lp lrd inv | e_ir e_st e_ov e_pc e_ctr
        vecs[0]  = mk(1, I_ADD, 30'h10, 13'h011, 1, 0, 5'd0, 0, 1, 0, 1, 30'h10, 13'h011);
        vecs[1]  = mk(1, I_ADD, 30'h20, 13'h022, 1, 0, 5'd0, 0, 1, 0, 1, 30'h20, 13'h022);
        vecs[2]  = mk(0, I_ADD, 30'h00, 13'h000, 1, 0, 5'd0, 0, 1, 0, 0, 30'h00, 13'h000);
        vecs[3]  = mk(1, I_ADD, 30'h30, 13'h033, 0, 0, 5'd0, 0, 1, 0, 1, 30'h30, 13'h033);
        vecs[4]  = mk(1, I_ADD, 30'h40, 13'h044, 0, 0, 5'd0, 0, 1, 0, 1, 30'h30, 13'h033);
        vecs[5]  = mk(1, I_ADD, 30'h50, 13'h055, 0, 0, 5'd0, 0, 0, 0, 1, 30'h30, 13'h033);
        vecs[6]  = mk(1, I_ADD, 30'h50, 13'h055, 1, 0, 5'd0, 0, 0, 0, 1, 30'h40, 13'h044);
        vecs[7]  = mk(1, I_ADD, 30'h50, 13'h055, 1, 0, 5'd0, 0, 1, 0, 1, 30'h50, 13'h055);
        vecs[8]  = mk(0, I_ADD, 30'h00, 13'h000, 1, 0, 5'd0, 0, 1, 0, 0, 30'h00, 13'h000);
        vecs[9]  = mk(1, I_ADD, 30'h60, 13'h066, 1, 1, 5'd2, 0, 0, 1, 0, 30'h00, 13'h000);
        vecs[10] = mk(1, I_ADD, 30'h60, 13'h066, 1, 0, 5'd2, 0, 1, 0, 1, 30'h60, 13'h066);
        vecs[11] = mk(1, I_X0,  30'h70, 13'h077, 1, 1, 5'd0, 0, 1, 0, 1, 30'h70, 13'h077);
        vecs[12] = mk(1, I_ADD, 30'h75, 13'h075, 1, 1, 5'd1, 0, 0, 1, 0, 30'h00, 13'h000);
        vecs[13] = mk(0, I_ADD, 30'h75, 13'h075, 1, 1, 5'd1, 0, 0, 0, 0, 30'h00, 13'h000);
        vecs[14] = mk(1, I_ADD, 30'h80, 13'h088, 0, 0, 5'd0, 0, 1, 0, 1, 30'h80, 13'h088);
        vecs[15] = mk(1, I_ADD, 30'h90, 13'h099, 0, 0, 5'd0, 0, 1, 0, 1, 30'h80, 13'h088);
        vecs[16] = mk(1, I_ADD, 30'hA0, 13'h0AA, 1, 0, 5'd0, 1, 0, 0, 0, 30'h00, 13'h000);
        vecs[17] = mk(0, I_ADD, 30'h00, 13'h000, 1, 0, 5'd0, 0, 1, 0, 0, 30'h00, 13'h000);
        vecs[18] = mk(1, I_ADD, 30'hB0, 13'h0BB, 1, 0, 5'd0, 1, 1, 0, 0, 30'h00, 13'h000);
        vecs[19] = mk(0, I_ADD, 30'h00, 13'h000, 1, 0, 5'd0, 0, 1, 0, 0, 30'h00, 13'h000);

        idle_inputs();
        async_rst_n = 1'b0;
        #12;
        cmp("reset out_valid", 64'(out_valid), 64'd0);
        cmp("reset ctr_out", 64'(ctr_out), 64'd0);
        cmp("reset pc_out", 64'(pc_out), 64'd0);
        cmp("reset rs1_out", 64'(rs1_out), 64'd0);
        cmp("reset in_ready", 64'(in_ready), 64'd1);
        $display("[TB] reset: out_valid=%0d ctr_out=0x%0h in_ready=%0d", out_valid, ctr_out, in_ready);
        @(negedge clk);
        async_rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            run_vec(vecs[i], i);
        end

        // Held operand under a writeback to its source register.
        @(negedge clk);
        idle_inputs();
        in_valid = 1'b1; inst_in = I_RS15; pc_in = 30'hC0; ctr_in = 13'h001;
        rs1_data_in = 32'h0000_1234; rs2_data_in = 32'h0000_5678;
        @(posedge clk); #1;
        cmp("hold cap rs1_out", 64'(rs1_out), 64'h1234);
        cmp("hold cap pc_out", 64'(pc_out), 64'hC0);
        $display("[TB] hold capture: rs1_out=0x%0h rs2_out=0x%0h", rs1_out, rs2_out);

        @(negedge clk);
        in_valid = 1'b0; rs1_data_in = '0; rs2_data_in = '0;
        wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
`ifdef DECODE_WB_BYPASS_EN
        exp_r1 = 32'hDEAD_BEEF;
`else
        exp_r1 = 32'h0000_1234;
`endif
        @(posedge clk); #1;
        cmp("wb rd=5 rs1_out", 64'(rs1_out), 64'(exp_r1));
        cmp("wb rd=5 rs2_out", 64'(rs2_out), 64'h5678);
        cmp("wb rd=5 out_valid", 64'(out_valid), 64'd1);
        $display("[TB] wb rd=5: rs1_out=0x%0h rs2_out=0x%0h", rs1_out, rs2_out);

        @(negedge clk);
        wb_rd = 5'd0; wb_data = 32'hCAFE_F00D;
        @(posedge clk); #1;
        cmp("wb rd=0 rs1_out", 64'(rs1_out), 64'(exp_r1));
        cmp("wb rd=0 rs2_out", 64'(rs2_out), 64'h5678);
        $display("[TB] wb rd=0: rs1_out=0x%0h rs2_out=0x%0h", rs1_out, rs2_out);

        // Capture-time forwarding into rs2 while the head pops.
        @(negedge clk);
        wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'hA5A5_A5A5;
        in_valid = 1'b1; inst_in = I_ADD; pc_in = 30'hD0; ctr_in = 13'h0DD;
        rs1_data_in = 32'h0000_1111; rs2_data_in = 32'h0000_2222; out_ready = 1'b1;
`ifdef DECODE_WB_BYPASS_EN
        exp_r2 = 32'hA5A5_A5A5;
`else
        exp_r2 = 32'h0000_2222;
`endif
        @(posedge clk); #1;
        cmp("cap pc_out", 64'(pc_out), 64'hD0);
        cmp("cap rs1_out", 64'(rs1_out), 64'h1111);
        cmp("cap rs2_out", 64'(rs2_out), 64'(exp_r2));
        $display("[TB] capture fwd: pc_out=0x%0h rs1_out=0x%0h rs2_out=0x%0h", pc_out, rs1_out, rs2_out);

        @(negedge clk);
        idle_inputs();
        out_ready = 1'b1;
        @(posedge clk); #1;
        cmp("drain out_valid", 64'(out_valid), 64'd0);

        // Fill head and skid, then pulse reset between clock edges.
        @(negedge clk);
        idle_inputs();
        in_valid = 1'b1; inst_in = I_ADD; pc_in = 30'hE0; ctr_in = 13'h0EE;
        @(posedge clk);
        @(negedge clk);
        pc_in = 30'hF0; ctr_in = 13'h0FF;
        @(posedge clk); #1;
        cmp("full out_valid", 64'(out_valid), 64'd1);
        cmp("full in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        async_rst_n = 1'b0;
        #1;
        cmp("async rst out_valid", 64'(out_valid), 64'd0);
        cmp("async rst ctr_out", 64'(ctr_out), 64'd0);
        cmp("async rst in_ready", 64'(in_ready), 64'd1);
        $display("[TB] async reset pulse: out_valid=%0d ctr_out=0x%0h", out_valid, ctr_out);
        #1;
        async_rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        cmp("post rst out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        cmp("post rst out_valid 2", 64'(out_valid), 64'd0);
        $display("[TB] after reset: out_valid=%0d in_ready=%0d", out_valid, in_ready);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
